// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the button debouncer
// Contents:
//   state_t        - debouncer FSM states
//   SYNC_RESET_VAL - synchronizer reset level (button released, btn_n = 1)
package debounce_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic SYNC_RESET_VAL = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with selectable reset value
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-low reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= {2{RESET_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/button_debounce.sv
// button_debounce: tick-sampled push-button debouncer with press/release pulses
// Ports:
//   clk           - system clock
//   reset         - asynchronous active-low reset
//   tick          - sample enable from the tick divider (may stay high)
//   btn_n         - raw asynchronous button, 0 = pressed
//   level         - debounced state, 1 = pressed
//   press_pulse   - one-clk pulse on accepted press (and auto-repeats)
//   release_pulse - one-clk pulse on accepted release
// Define BUTTON_DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses while held.
module button_debounce import debounce_pkg::*; #(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  if (STABLE_TICKS < 1 || STABLE_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("button_debounce: parameter out of range");
  end
  logic btn_s;
  logic p;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic cnt_done;
  logic rep_fire;
  sync_2ff #(.RESET_VAL(SYNC_RESET_VAL)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(btn_n),
    .q(btn_s)
  );
  assign p = ~btn_s;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  // this qualifying tick completes the run of equal samples
  assign cnt_done = (32'(cnt) + 1) == STABLE_TICKS;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RW-1:0] rcnt;
  logic rep_wrap;
  // after the first repeat the counter folds back to REPEAT_DELAY so it
  // only ever needs to reach REPEAT_DELAY + REPEAT_RATE
  assign rep_wrap = (32'(rcnt) + 1) == REPEAT_DELAY + REPEAT_RATE;
  assign rep_fire = tick && p && state == PRESSED && ((32'(rcnt) + 1) == REPEAT_DELAY || rep_wrap);
  always_ff @(posedge clk or negedge reset)
    if (!reset) rcnt <= '0;
    else if (state != PRESSED) rcnt <= '0;
    else if (tick && p) rcnt <= rep_wrap ? RW'(REPEAT_DELAY) : rcnt + 1'b1;
`else
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      if (tick)
        case (state)
          IDLE:
            if (p) begin
              cnt <= CW'(1);
              if (STABLE_TICKS == 1) begin
                state <= PRESSED;
                level <= 1'b1;
                press_pulse <= 1'b1;
              end else state <= PRESS_WAIT;
            end
          PRESS_WAIT:
            if (!p) begin
              state <= IDLE;
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_done) begin
                state <= PRESSED;
                level <= 1'b1;
                press_pulse <= 1'b1;
              end
            end
          PRESSED:
            if (!p) begin
              cnt <= CW'(1);
              if (STABLE_TICKS == 1) begin
                state <= IDLE;
                level <= 1'b0;
                release_pulse <= 1'b1;
              end else state <= RELEASE_WAIT;
            end else press_pulse <= rep_fire;
          RELEASE_WAIT:
            if (p) begin
              state <= PRESSED;
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_done) begin
                state <= IDLE;
                level <= 1'b0;
                release_pulse <= 1'b1;
              end
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: self-checking bench for button_debounce
module tb_button_debounce;
  localparam int ST = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  typedef struct {
    logic b;
    logic t;
    logic l;
    logic pp;
    logic rp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic btn_n = 1'b1;
  logic level;
  logic press_pulse;
  logic release_pulse;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  button_debounce #(.STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .btn_n(btn_n),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );
  // reference: a level flips after ST consecutive ticks disagreeing with it;
  // raw samples reach the decision two clk edges late
  logic hist[$];
  logic m_p;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_rel = 1'b0;
  int m_run = 0;
  int m_held = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist = '{1'b1, 1'b1};
      m_run = 0;
      m_held = 0;
      m_level = 1'b0;
      m_press = 1'b0;
      m_rel = 1'b0;
    end else begin
      m_p = ~hist[0];
      m_press = 1'b0;
      m_rel = 1'b0;
      if (tick) begin
        if (m_p != m_level) begin
          m_run++;
          m_held = 0;
          if (m_run == ST) begin
            m_level = m_p;
            m_run = 0;
            m_press = m_p;
            m_rel = ~m_p;
          end
        end else begin
          m_held = (m_level && m_run == 0) ? m_held + 1 : 0;
          m_run = 0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
          if (m_level && m_held >= RD && (m_held - RD) % RR == 0) m_press = 1'b1;
`endif
        end
      end
      hist.push_back(btn_n);
      void'(hist.pop_front());
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic b, input logic t);
    btn_n = b;
    tick = t;
    @(negedge clk);
  endtask
  initial begin
    vec_t vecs[$];
    int np;
    int nr;
    int rel_at;
    logic lvl_seen;
    int seg;
    logic b;
    repeat (3) @(negedge clk);
    chk("reset_level", level, 0);
    chk("reset_press", press_pulse, 0);
    chk("reset_release", release_pulse, 0);
    reset = 1'b1;
    // press then release with tick held high: 6 edges each way
    for (int i = 1; i <= 2; i++) vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 1; i <= 8; i++) vecs.push_back(vec_t'{1'b0, 1'b1, logic'(i >= 6), logic'(i == 6), 1'b0});
    for (int i = 1; i <= 8; i++) vecs.push_back(vec_t'{1'b1, 1'b1, logic'(i < 6), 1'b0, logic'(i == 6)});
    for (int i = 1; i <= 3; i++) vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].b, vecs[i].t);
      chk($sformatf("vec%0d_level", i), level, vecs[i].l);
      chk($sformatf("vec%0d_press", i), press_pulse, vecs[i].pp);
      chk($sformatf("vec%0d_release", i), release_pulse, vecs[i].rp);
    end
    // release with a one-clk glitch back to pressed: release moves to step 10
    repeat (8) step(1'b0, 1'b1);
    chk("glitch_pre_level", level, 1);
    nr = 0;
    rel_at = 0;
    lvl_seen = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step((i == 4) ? 1'b0 : 1'b1, 1'b1);
      if (release_pulse) begin
        nr++;
        rel_at = i;
      end
      if (i < 10 && !level) lvl_seen = 1'b0;
    end
    chk("glitch_release_count", nr, 1);
    chk("glitch_release_step", rel_at, 10);
    chk("glitch_level_held", lvl_seen, 1);
    chk("glitch_final_level", level, 0);
    // bounce every 2 clks never reaches ST stable ticks
    np = 0;
    nr = 0;
    lvl_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step((i < 20) ? logic'((i / 2) % 2) : 1'b1, 1'b1);
      np += int'(press_pulse);
      nr += int'(release_pulse);
      if (level) lvl_seen = 1'b1;
    end
    chk("bounce_press", np, 0);
    chk("bounce_release", nr, 0);
    chk("bounce_level", lvl_seen, 0);
    // tick every 5 clks: press on the 4th tick, level frozen between ticks
    repeat (3) step(1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) step(1'b0, 1'b0);
      chk($sformatf("gate_idle_level%0d", k), level, (k == 4) ? 0 : 0);
      step(1'b0, 1'b1);
      chk($sformatf("gate_tick_level%0d", k), level, k == 4);
      chk($sformatf("gate_tick_press%0d", k), press_pulse, k == 4);
    end
    repeat (2) step(1'b0, 1'b0);
    chk("gate_hold_level", level, 1);
    chk("gate_hold_press", press_pulse, 0);
    repeat (8) step(1'b1, 1'b1);
    chk("gate_released", level, 0);
    // reset during PRESS_WAIT with cnt = 3 discards the partial count
    repeat (5) step(1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_level", level, 0);
    chk("rst_mid_press", press_pulse, 0);
    chk("rst_mid_release", release_pulse, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("rst_after_press%0d", i), press_pulse, i == 6);
      chk($sformatf("rst_after_level%0d", i), level, i == 6);
    end
    // asynchronous reset clears a pressed level without a clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_async_level", level, 0);
    @(negedge clk);
    btn_n = 1'b1;
    reset = 1'b1;
    repeat (4) step(1'b1, 1'b1);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    repeat (5) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rep_accept", press_pulse, 1);
    for (int t = 1; t <= 20; t++) begin
      step(1'b0, 1'b1);
      chk($sformatf("rep_tick%0d", t), press_pulse, t >= RD && (t - RD) % RR == 0);
    end
    repeat (8) step(1'b1, 1'b1);
    chk("rep_released", level, 0);
`endif
    // random runs of raw levels and sparse ticks against the reference
    for (int n = 0; n < 3000; n += seg) begin
      seg = $urandom_range(1, ($urandom_range(0, 4) == 0) ? 30 : 6);
      b = logic'($urandom_range(0, 1));
      for (int j = 0; j < seg; j++) begin
        step(b, logic'($urandom_range(0, 3) != 0));
        chk("rnd_level", level, m_level);
        chk("rnd_press", press_pulse, m_press);
        chk("rnd_release", release_pulse, m_rel);
        chk("rnd_exclusive", press_pulse & release_pulse, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
